// File: rtl/segasys1_prgrom_arb_pkg.sv
// Shared types and sizing helpers for the System 1 program ROM arbiter.
package segasys1_prgrom_arb_pkg;

    localparam int unsigned DefaultAw = 15;

    typedef enum logic [1:0] {
        StIdle,
        StAccA,
        StAccB
    } arb_state_e;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/segasys1_prgrom_arb.sv
// Two-port arbiter for the main program ROM: CPU fetches get decrypted bytes,
// the secondary reader gets raw bytes; each access holds the address ACC_LEN cycles.
module segasys1_prgrom_arb
    import segasys1_prgrom_arb_pkg::*;
#(
    parameter int unsigned AW         = DefaultAw,
    parameter int unsigned ACC_LEN    = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_m1,
    input  logic [AW-1:0] cpu_ad,
    output logic [7:0]    cpu_dt,
    output logic          cpu_ack,
    output logic          cpu_wait,
    input  logic          sec_req,
    input  logic [AW-1:0] sec_ad,
    output logic [7:0]    sec_dt,
    output logic          sec_ack,
    output logic          dec_m1,
    output logic [AW-1:0] dec_ad,
    input  logic [7:0]    dec_dt,
    input  logic [7:0]    raw_dt
);

    localparam int unsigned CW = cnt_width(ACC_LEN);
    localparam int unsigned SW = cnt_width(STARVE_MAX + 1);
    localparam logic [CW-1:0] CntLast   = CW'(ACC_LEN - 1);
    localparam logic [SW-1:0] StarveLim = SW'(STARVE_MAX);

    arb_state_e    state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          grant_a;
    logic          grant_b;

    // The secondary port wins a tie only once the CPU has had its quota.
    assign grant_b  = sec_req & (~cpu_req | (starve >= StarveLim));
    assign grant_a  = cpu_req & ~grant_b;
    assign cpu_wait = cpu_req & ~cpu_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            cnt     <= '0;
            starve  <= '0;
            dec_ad  <= '0;
            dec_m1  <= 1'b0;
            cpu_dt  <= '0;
            sec_dt  <= '0;
            cpu_ack <= 1'b0;
            sec_ack <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            sec_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!sec_req) starve <= '0;
                    if (grant_b) begin
                        state  <= StAccB;
                        dec_ad <= sec_ad;
                        dec_m1 <= 1'b0;
                        cnt    <= '0;
                        starve <= '0;
                    end else if (grant_a) begin
                        state  <= StAccA;
                        dec_ad <= cpu_ad;
                        dec_m1 <= cpu_m1;
                        cnt    <= '0;
                        if (sec_req && (starve < StarveLim)) starve <= starve + 1'b1;
                    end
                end
                StAccA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CntLast) begin
                        state <= StIdle;
                        // An abandoned access completes silently and keeps the old byte.
                        if (cpu_req) begin
                            cpu_dt  <= dec_dt;
                            cpu_ack <= 1'b1;
                        end
                    end
                end
                StAccB: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CntLast) begin
                        state <= StIdle;
                        if (sec_req) begin
                            sec_dt  <= raw_dt;
                            sec_ack <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
